// File: rtl/icache_ctrl_if.sv
// Fetch / SRAM / memory signal bundle for the I-cache miss controller.
// master = controller side, slave = fetch stage, SRAM and memory side.
interface icache_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_ready;
    logic [31:0]       cpu_instr;

    logic              sram_en;
    logic              sram_memWen;
    logic [ADDR_W-5:0] sram_blockAddr;
    logic [127:0]      sram_dataIn;
    logic              sram_hit;
    logic [127:0]      sram_dataOut;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        input  cpu_req, cpu_addr, sram_hit, sram_dataOut, mem_gnt, mem_rvalid, mem_rdata,
        output cpu_ready, cpu_instr, sram_en, sram_memWen, sram_blockAddr, sram_dataIn,
               mem_req, mem_addr
    );

    modport slave (
        output cpu_req, cpu_addr, sram_hit, sram_dataOut, mem_gnt, mem_rvalid, mem_rdata,
        input  cpu_ready, cpu_instr, sram_en, sram_memWen, sram_blockAddr, sram_dataIn,
               mem_req, mem_addr
    );
endinterface

// File: rtl/icache_ctrl.sv
// I-cache miss controller: zero-wait hits, misses fetch 4 beats then FILL+RESP (7 cycles best case).
// Fetch stalls (cpu_ready=0) until the block is filled; mem_req is held until mem_gnt.
module icache_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int BLOCK_WORDS = 4,
    parameter int INDEX_W     = 5,
    parameter int TAG_W       = ADDR_W - INDEX_W - 4
) (
    input  logic          clk,
    input  logic          rst,
    icache_ctrl_if.master bus,
    output logic [31:0]   hit_count,
    output logic [31:0]   miss_count
);
    localparam int BLK_W = TAG_W + INDEX_W;
    localparam int CNT_W = $clog2(BLOCK_WORDS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLOCK_WORDS - 1);

    typedef enum logic [2:0] {IDLE, MEM_REQ, MEM_WAIT, FILL, RESP} state_t;

    state_t                        state, state_nxt;
    logic [ADDR_W-3:0]             miss_addr;
    logic [CNT_W-1:0]              beat_cnt;
    logic [BLOCK_WORDS-1:0][31:0]  line_buf;
    logic [BLK_W-1:0]              miss_blk;
    logic                          lookup_hit;

    assign miss_blk   = miss_addr[ADDR_W-3:2];
    assign lookup_hit = (state == IDLE) && bus.cpu_req && bus.sram_hit;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (bus.cpu_req && !bus.sram_hit) state_nxt = MEM_REQ;
            MEM_REQ:  if (bus.mem_gnt) state_nxt = MEM_WAIT;
            MEM_WAIT: if (bus.mem_rvalid && beat_cnt == LAST_BEAT) state_nxt = FILL;
            FILL:     state_nxt = RESP;
            RESP:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // The SRAM rewrites the hit way on every enabled hit, so pass its data straight back.
    always_comb begin
        bus.cpu_ready      = 1'b0;
        bus.cpu_instr      = '0;
        bus.sram_en        = 1'b0;
        bus.sram_memWen    = 1'b0;
        bus.sram_blockAddr = '0;
        bus.sram_dataIn    = bus.sram_dataOut;
        bus.mem_req        = 1'b0;
        bus.mem_addr       = '0;
        case (state)
            IDLE: begin
                bus.sram_en        = bus.cpu_req;
                bus.sram_blockAddr = bus.cpu_addr[ADDR_W-1:4];
                if (lookup_hit) begin
                    bus.cpu_ready = 1'b1;
                    bus.cpu_instr = bus.sram_dataOut[{bus.cpu_addr[3:2], 5'd0} +: 32];
                end
            end
            MEM_REQ: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = {miss_blk, 4'b0000};
            end
            FILL: begin
                bus.sram_en        = 1'b1;
                bus.sram_memWen    = 1'b1;
                bus.sram_blockAddr = miss_blk;
                bus.sram_dataIn    = line_buf;
            end
            RESP: begin
                bus.cpu_ready = 1'b1;
                bus.cpu_instr = line_buf[miss_addr[1:0]];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            miss_addr  <= '0;
            beat_cnt   <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                IDLE: if (bus.cpu_req) begin
                    if (bus.sram_hit) begin
                        if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
                    end else begin
                        miss_addr <= bus.cpu_addr[ADDR_W-1:2];
                        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
                    end
                end
                MEM_REQ:  if (bus.mem_gnt) beat_cnt <= '0;
                MEM_WAIT: if (bus.mem_rvalid) beat_cnt <= beat_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    // Buffer contents are don't-care out of reset, so no reset term here.
    always_ff @(posedge clk) begin
        if (!rst && state == MEM_WAIT && bus.mem_rvalid)
            line_buf[beat_cnt] <= bus.mem_rdata;
    end
endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: 2-way LRU SRAM and randomized memory responder around the DUT,
// with an LRU tag-list reference model and a backing-memory image for expected data.
module tb_icache_ctrl;
    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    icache_ctrl_if #(.ADDR_W(ADDR_W)) bus ();
    logic [31:0] hit_count, miss_count;

    icache_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- 2-way SRAM with LRU replacement ----------------
    logic         sram_clr;
    logic [22:0]  s_tag  [2][32];
    logic         s_vld  [2][32];
    logic [127:0] s_data [2][32];
    logic         s_lru  [32];
    logic         s_hit, s_way;
    wire  [4:0]   s_idx = bus.sram_blockAddr[4:0];
    wire  [22:0]  s_tg  = bus.sram_blockAddr[27:5];

    always_comb begin
        s_hit = 1'b0;
        s_way = 1'b0;
        for (int w = 0; w < 2; w++)
            if (s_vld[w][s_idx] && s_tag[w][s_idx] == s_tg) begin
                s_hit = 1'b1;
                s_way = w[0];
            end
    end

    assign bus.sram_hit     = bus.sram_en & s_hit;
    assign bus.sram_dataOut = (bus.sram_en && s_hit) ? s_data[s_way][s_idx] : '0;

    always @(posedge clk) begin
        logic vic;
        if (sram_clr) begin
            for (int i = 0; i < 32; i++) begin
                s_vld[0][i] <= 1'b0;
                s_vld[1][i] <= 1'b0;
                s_lru[i]    <= 1'b0;
            end
        end else if (bus.sram_en) begin
            if (bus.sram_memWen) begin
                vic = !s_vld[0][s_idx] ? 1'b0 : (!s_vld[1][s_idx] ? 1'b1 : s_lru[s_idx]);
                s_vld[vic][s_idx]  <= 1'b1;
                s_tag[vic][s_idx]  <= s_tg;
                s_data[vic][s_idx] <= bus.sram_dataIn;
                s_lru[s_idx]       <= ~vic;
            end else if (s_hit) begin
                s_data[s_way][s_idx] <= bus.sram_dataIn;
                s_lru[s_idx]         <= ~s_way;
            end
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] img [1024];
    logic [22:0] rlist [32][$];
    int unsigned ref_hits = 0, ref_misses = 0;

    function automatic bit ref_access(input logic [31:0] a);
        logic [4:0]  idx = a[8:4];
        logic [22:0] tg  = a[31:9];
        foreach (rlist[idx][i])
            if (rlist[idx][i] == tg) begin
                rlist[idx].delete(i);
                rlist[idx].push_front(tg);
                return 1'b1;
            end
        rlist[idx].push_front(tg);
        if (rlist[idx].size() > 2) void'(rlist[idx].pop_back());
        return 1'b0;
    endfunction

    task automatic idle_cycle();
        @(posedge clk); #1;
        bus.cpu_req    = 1'b0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        @(negedge clk);
        check("idle_ready", bus.cpu_ready, 0);
        check("idle_sram_en", bus.sram_en, 0);
        check("hit_count", hit_count, ref_hits);
        check("miss_count", miss_count, ref_misses);
    endtask

    // One fetch: g = grant delay, gap_max = max idle cycles before each beat,
    // noise = stray rvalid/gnt in MEM_REQ, FILL and RESP.
    task automatic fetch(input logic [31:0] addr, input int g, input int gap_max,
                         input bit noise, input bit do_alt, input logic [31:0] alt_addr);
        bit           exp_hit;
        int           beat_cyc [4];
        int           lat;
        logic [127:0] blk;
        logic [31:0]  word;
        exp_hit = ref_access(addr);
        if (exp_hit) ref_hits++; else ref_misses++;
        for (int k = 0; k < 4; k++) blk[32*k +: 32] = img[{addr[11:4], 2'(k)}];
        word = img[addr[11:2]];

        @(posedge clk); #1;
        bus.cpu_req    = 1'b1;
        bus.cpu_addr   = addr;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        @(negedge clk);
        check("lookup_ready", bus.cpu_ready, exp_hit);
        check("lookup_sram_en", bus.sram_en, 1);
        check("lookup_blkaddr", bus.sram_blockAddr, addr[31:4]);
        if (exp_hit) begin
            check("hit_instr", bus.cpu_instr, word);
            check("hit_passthru", bus.sram_dataIn, bus.sram_dataOut);
            check("hit_wen", bus.sram_memWen, 0);
            check("hit_mem_req", bus.mem_req, 0);
        end else begin
            beat_cyc[0] = 2 + g + $urandom_range(0, gap_max);
            for (int k = 1; k < 4; k++) beat_cyc[k] = beat_cyc[k-1] + 1 + $urandom_range(0, gap_max);
            lat = beat_cyc[3] + 2;
            for (int cyc = 1; cyc <= lat; cyc++) begin
                int bi;
                @(posedge clk); #1;
                if (do_alt && cyc == 3) bus.cpu_addr = alt_addr;
                bi = -1;
                for (int k = 0; k < 4; k++) if (beat_cyc[k] == cyc) bi = k;
                bus.mem_gnt    = (cyc == 1 + g);
                bus.mem_rvalid = (bi >= 0);
                bus.mem_rdata  = (bi >= 0) ? img[{addr[11:4], 2'(bi)}] : $urandom;
                if (noise && (cyc == 1 || cyc >= lat - 1)) begin
                    bus.mem_rvalid = 1'b1;
                    if (cyc >= lat - 1) bus.mem_gnt = 1'b1;
                end
                @(negedge clk);
                check("miss_mem_req", bus.mem_req, (cyc <= 1 + g));
                if (bus.mem_req) check("miss_mem_addr", bus.mem_addr, {addr[31:4], 4'b0});
                if (cyc == lat - 1) begin
                    check("fill_wen", bus.sram_memWen, 1);
                    check("fill_en", bus.sram_en, 1);
                    check("fill_blkaddr", bus.sram_blockAddr, addr[31:4]);
                    check("fill_data", bus.sram_dataIn, blk);
                end else begin
                    check("stall_wen", bus.sram_memWen, 0);
                    check("stall_en", bus.sram_en, 0);
                end
                check("miss_ready", bus.cpu_ready, (cyc == lat));
                if (cyc == lat) check("miss_instr", bus.cpu_instr, word);
            end
        end
        idle_cycle();
    endtask

    task automatic reset_midfetch(input logic [31:0] addr);
        @(posedge clk); #1;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = addr;
        @(negedge clk);
        check("rst_lookup_ready", bus.cpu_ready, 0);
        @(posedge clk); #1;
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        check("rst_mem_req", bus.mem_req, 1);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = $urandom;
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        bus.cpu_req    = 1'b0;
        rst            = 1'b1;
        @(negedge clk);
        ref_hits   = 0;
        ref_misses = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            rst            = 1'b0;
            bus.mem_rvalid = (k < 3);
            bus.mem_gnt    = (k == 1);
            bus.mem_rdata  = $urandom;
            @(negedge clk);
            check("post_rst_mem_req", bus.mem_req, 0);
            check("post_rst_ready", bus.cpu_ready, 0);
            check("post_rst_wen", bus.sram_memWen, 0);
            check("post_rst_hits", hit_count, 0);
            check("post_rst_misses", miss_count, 0);
        end
        idle_cycle();
    endtask

    initial begin
        logic [31:0] a;
        bus.cpu_req    = 1'b0;
        bus.cpu_addr   = '0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        sram_clr       = 1'b1;
        for (int i = 0; i < 1024; i++) img[i] = $urandom;
        for (int i = 0; i < 4; i++) img[32'h40 + i] = 32'hA0 + i;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", bus.cpu_ready, 0);
        check("reset_instr", bus.cpu_instr, 0);
        check("reset_mem_req", bus.mem_req, 0);
        check("reset_mem_addr", bus.mem_addr, 0);
        check("reset_wen", bus.sram_memWen, 0);
        check("reset_en", bus.sram_en, 0);
        check("reset_hits", hit_count, 0);
        check("reset_misses", miss_count, 0);
        @(posedge clk); #1;
        rst      = 1'b0;
        sram_clr = 1'b0;

        fetch(32'h0000_0104, 0, 0, 0, 0, '0);
        fetch(32'h0000_010C, 0, 0, 0, 0, '0);
        fetch(32'h0000_0000, 0, 0, 0, 0, '0);
        fetch(32'h0000_0200, 0, 0, 0, 0, '0);
        fetch(32'h0000_0400, 1, 1, 0, 0, '0);
        fetch(32'h0000_0200, 0, 0, 0, 0, '0);
        fetch(32'h0000_0000, 0, 0, 0, 0, '0);
        fetch(32'h0000_0848, 3, 3, 1, 0, '0);
        fetch(32'h0000_0A48, 0, 1, 0, 1, 32'h0000_0300);
        fetch(32'h8000_0104, 2, 0, 1, 0, '0);
        reset_midfetch(32'h0000_0F84);
        fetch(32'h0000_0F84, 0, 0, 0, 0, '0);
        fetch(32'h0000_0F88, 0, 0, 0, 0, '0);

        for (int n = 0; n < 150; n++) begin
            a = {$urandom_range(0, 1) == 1, 19'b0, 3'($urandom_range(0, 7)), 3'b0,
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            fetch(a, $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) == 0, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Miss-handling controller that sits between the instruction-fetch stage and the 2-way, 1KB, 16-byte-block I-cache SRAM.
- Performs the tag lookup and returns the selected 32-bit instruction on a hit.
- On a miss it stalls the fetch stage, fetches the 4-word block from memory, and writes it into the SRAM with `memWen`.
- It then returns the missed word and keeps hit/miss performance counters.

Parameters:
- ADDR_W, 32: byte address width.
- BLOCK_WORDS, 4: 32-bit words per block; 128-bit block.
- INDEX_W, 5: set index bits (32 sets).
- TAG_W, 23: ADDR_W - INDEX_W - 4.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- cpu_req  input  1  fetch request; held with cpu_addr until cpu_ready.
- cpu_addr  input  ADDR_W  byte address; bits [1:0] ignored.
- cpu_ready  output  1  instruction valid this cycle; request completes.
- cpu_instr  output  32  fetched instruction.
- sram_en  output  1  SRAM enable.
- sram_memWen  output  1  SRAM fill strobe.
- sram_blockAddr  output  TAG_W+INDEX_W  {tag,index} = addr[ADDR_W-1:4].
- sram_dataIn  output  128  write data to the SRAM.
- sram_hit  input  1  combinational hit from the SRAM.
- sram_dataOut  input  128  hit block; word0 at [31:0].
- mem_req  output  1  block read request; held until mem_gnt.
- mem_addr  output  ADDR_W  block-aligned address, {blockAddr,4'b0}.
- mem_gnt  input  1  request accepted this cycle.
- mem_rvalid  input  1  one data beat is valid.
- mem_rdata  input  32  beat data; words arrive in ascending order 0..3.
- hit_count  output  32  lookups that hit.
- miss_count  output  32  lookups that missed.

Behaviour:
- States: IDLE, MEM_REQ, MEM_WAIT, FILL, RESP. Reset and rst=1 mid-operation force IDLE.
- Reset values: all outputs 0; beat_cnt 0; counters 0; line buffer contents don't care.
- SRAM write rule: the SRAM rewrites the hit way's data and updates PLRU on every enabled hit cycle. Therefore:
  - sram_dataIn = sram_dataOut whenever sram_memWen=0.
  - sram_en is asserted only in IDLE with cpu_req=1, and in FILL.
- IDLE:
  - sram_en = cpu_req; sram_blockAddr = cpu_addr[ADDR_W-1:4].
  - If cpu_req && sram_hit: cpu_ready=1 in the same cycle (combinational, zero-wait). cpu_instr = sram_dataOut word cpu_addr[3:2]. hit_count++. Stay in IDLE.
  - If cpu_req && !sram_hit: latch cpu_addr[ADDR_W-1:2]. miss_count++. Go to MEM_REQ.
- MEM_REQ:
  - mem_req=1; mem_addr from the latched address.
  - On mem_gnt: beat_cnt=0, go to MEM_WAIT.
  - mem_rvalid is ignored in this state.
- MEM_WAIT:
  - Each mem_rvalid stores mem_rdata into buffer word beat_cnt, then beat_cnt++.
  - Gaps between beats are allowed.
  - The rvalid with beat_cnt==BLOCK_WORDS-1 moves to FILL.
- FILL (1 cycle):
  - sram_en=1, sram_memWen=1, sram_blockAddr = latched address, sram_dataIn = buffer.
  - Go to RESP.
- RESP (1 cycle):
  - cpu_ready=1; cpu_instr = buffer word at the latched addr[3:2].
  - No SRAM access, so no second PLRU update.
  - Go to IDLE.
- cpu_ready=0 in MEM_REQ, MEM_WAIT and FILL. Changes to cpu_addr during a miss are ignored; the response is for the latched address.
- Miss latency: 1 (IDLE) + grant wait + 4 beats + FILL + RESP. With immediate grant and back-to-back beats, cpu_ready occurs 7 cycles after the miss cycle.
- mem_rvalid/mem_gnt arriving in IDLE, FILL or RESP are ignored. Stale beats after a reset are dropped.
- Counters saturate at 32'hFFFFFFFF; they do not wrap.
- cpu_req=0 in IDLE: no SRAM access, counters unchanged.

Test Plan:
- Cold miss at 0x0000_0104:
  - Stimulus: immediate mem_gnt; beats 0xA0,0xA1,0xA2,0xA3.
  - Expected: mem_addr=0x100; one FILL cycle with blockAddr=0x10; cpu_ready with instr 0xA1 seven cycles after the request; miss_count=1.
- Hit after fill:
  - Stimulus: request 0x10C.
  - Expected: cpu_ready in the same cycle, instr 0xA3; sram_dataIn equals sram_dataOut; hit_count=1; mem_req never asserted.
- Conflict:
  - Stimulus: fill 0x0000, 0x0200 and 0x0400 (same index 0), then re-read 0x0200.
  - Expected: hit; 0x0000 misses again (evicted by PLRU); miss_count=4.
- Slow memory:
  - Stimulus: mem_gnt after 3 cycles; idle gaps between beats; mem_rvalid pulsed in MEM_REQ.
  - Expected: early beat ignored; buffer holds exactly 4 correct beats; cpu_ready held 0 throughout.
- Reset mid-fetch:
  - Stimulus: rst=1 after 2 beats; late beats arrive in IDLE.
  - Expected: next cycle state IDLE, mem_req=0, counters 0, no sram_memWen; a subsequent request re-misses and fetches cleanly.
- Address change while stalled:
  - Stimulus: cpu_addr switches to 0x300 during MEM_WAIT.
  - Expected: fill and response are for the latched block; instr is from the latched word.
